text_writer: RTL and testbench

Terminal-style writer that sits directly upstream of the character RAM read by the character generator. It consumes a byte stream (ASCII with a few control codes) over a valid/ready handshake, tracks a cursor on the 80×40 text grid, and issues single-cycle write strobes into the RAM at linear address row*80+col. It clears the whole screen after reset and on form feed, and clears a row each time the cursor enters it on a newline.

---
 rtl/text_writer.sv | 200 ++++++++++++++++++++
 tb/tb_text_writer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_writer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// text_writer
//
// Terminal-style writer feeding the character RAM of an 80x40 text display.
// Accepts a byte stream over a valid/ready handshake, keeps a cursor, and
// issues single-cycle write strobes at linear address row*COLS+col. The whole
// screen is blanked after reset and on form feed. A row is blanked each time
// the cursor enters it on a newline or a line wrap.
//
// Ports
//   clock100   in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   char_in    in   byte to process
//   char_valid in   char_in is valid
//   char_ready out  a byte can be accepted this cycle (IDLE only)
//   ram_we     out  write strobe, one cell per cycle
//   ram_addr   out  write address = row*COLS + col
//   ram_data   out  byte written
//   cursor_col out  current column 0..COLS-1
//   cursor_row out  current row 0..ROWS-1
//   busy       out  high in any state other than IDLE
// -----------------------------------------------------------------------------
module text_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 40,
  parameter int ADDR_W = 12
) (
  input  logic              clock100,
  input  logic              reset_n,
  input  logic [7:0]        char_in,
  input  logic              char_valid,
  output logic              char_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic [6:0]        cursor_col,
  output logic [5:0]        cursor_row,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_PUT,
    S_CLR_LINE
  } state_t;

  localparam logic [7:0]        SPACE      = 8'h20;
  localparam logic [ADDR_W-1:0] CLEAR_END  = ADDR_W'(COLS * ROWS);
  localparam logic [ADDR_W-1:0] LINE_END   = ADDR_W'(COLS);
  localparam logic [6:0]        LAST_COL   = 7'(COLS - 1);
  localparam logic [5:0]        LAST_ROW   = 6'(ROWS - 1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [6:0]        r_col, w_col_nxt;
  logic [5:0]        r_row, w_row_nxt;
  logic              r_ram_we, w_ram_we_nxt;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
  logic [7:0]        r_ram_data, w_ram_data_nxt;
  logic              r_char_ready, w_char_ready_nxt;
  logic              r_busy, w_busy_nxt;

  logic [ADDR_W-1:0] w_row_ext;
  logic [ADDR_W-1:0] w_row_base;
  logic [5:0]        w_row_adv;
  logic              w_accept;
  logic              w_printable;

  // row*80 as (row<<6)+(row<<4): two shifts and an add, no multiplier.
  assign w_row_ext   = ADDR_W'(r_row);
  assign w_row_base  = (w_row_ext << 6) + (w_row_ext << 4);
  // The screen never scrolls; advancing past the last row wraps to the top.
  assign w_row_adv   = (r_row == LAST_ROW) ? 6'd0 : r_row + 6'd1;
  assign w_accept    = r_char_ready & char_valid;
  assign w_printable = (char_in >= 8'h20) && (char_in <= 8'h7E);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the value.
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_col_nxt      = r_col;
    w_row_nxt      = r_row;
    w_ram_we_nxt   = 1'b0;
    w_ram_addr_nxt = r_ram_addr;
    w_ram_data_nxt = r_ram_data;

    case (r_state)
      // One cell per cycle; the cycle after the last write drops into IDLE
      // so char_ready rises one edge after address COLS*ROWS-1 is written.
      S_CLEAR: begin
        if (r_cnt == CLEAR_END) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_ram_we_nxt   = 1'b1;
          w_ram_addr_nxt = r_cnt;
          w_ram_data_nxt = SPACE;
          w_cnt_nxt      = r_cnt + 1'b1;
        end
      end

      S_IDLE: begin
        if (w_accept) begin
          if (w_printable) begin
            // The write of the old cell is issued on the accept edge itself.
            w_ram_we_nxt   = 1'b1;
            w_ram_addr_nxt = w_row_base + ADDR_W'(r_col);
            w_ram_data_nxt = char_in;
            if (r_col == LAST_COL) begin
              w_col_nxt   = 7'd0;
              w_row_nxt   = w_row_adv;
              w_cnt_nxt   = '0;
              w_state_nxt = S_CLR_LINE;
            end else begin
              w_col_nxt   = r_col + 7'd1;
              w_state_nxt = S_PUT;
            end
          end else if (char_in == 8'h0D) begin
            w_col_nxt = 7'd0;
          end else if (char_in == 8'h0A) begin
            w_col_nxt   = 7'd0;
            w_row_nxt   = w_row_adv;
            w_cnt_nxt   = '0;
            w_state_nxt = S_CLR_LINE;
          end else if (char_in == 8'h08) begin
            if (r_col != 7'd0) begin
              w_col_nxt      = r_col - 7'd1;
              w_ram_we_nxt   = 1'b1;
              w_ram_addr_nxt = w_row_base + ADDR_W'(r_col - 7'd1);
              w_ram_data_nxt = SPACE;
              w_state_nxt    = S_PUT;
            end
          end else if (char_in == 8'h0C) begin
            w_col_nxt   = 7'd0;
            w_row_nxt   = 6'd0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_CLEAR;
          end
        end
      end

      // The strobe registered on the accept edge is visible during PUT.
      S_PUT: begin
        w_state_nxt = S_IDLE;
      end

      // r_row already holds the freshly entered row.
      S_CLR_LINE: begin
        if (r_cnt == LINE_END) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_ram_we_nxt   = 1'b1;
          w_ram_addr_nxt = w_row_base + r_cnt;
          w_ram_data_nxt = SPACE;
          w_cnt_nxt      = r_cnt + 1'b1;
        end
      end
    endcase

    w_char_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt       = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clock100 or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_CLEAR;
      r_cnt        <= '0;
      r_col        <= 7'd0;
      r_row        <= 6'd0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_data   <= SPACE;
      r_char_ready <= 1'b0;
      r_busy       <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_col        <= w_col_nxt;
      r_row        <= w_row_nxt;
      r_ram_we     <= w_ram_we_nxt;
      r_ram_addr   <= w_ram_addr_nxt;
      r_ram_data   <= w_ram_data_nxt;
      r_char_ready <= w_char_ready_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign char_ready = r_char_ready;
  assign ram_we     = r_ram_we;
  assign ram_addr   = r_ram_addr;
  assign ram_data   = r_ram_data;
  assign cursor_col = r_col;
  assign cursor_row = r_row;
  assign busy       = r_busy;

endmodule

// File: tb/tb_text_writer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_text_writer
//
// Drives text_writer with directed sequences and random bytes. A screen-level
// model (cursor arithmetic plus a queue of expected RAM writes and the number
// of busy cycles each byte costs) predicts the DUT; one process compares the
// DUT against it on every falling clock edge outside reset.
// -----------------------------------------------------------------------------
module tb_text_writer;

  localparam int COLS   = 80;
  localparam int ROWS   = 40;
  localparam int ADDR_W = 12;

  logic              clock100 = 1'b0;
  logic              reset_n  = 1'b1;
  logic [7:0]        char_in  = 8'h00;
  logic              char_valid = 1'b0;
  logic              char_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic [6:0]        cursor_col;
  logic [5:0]        cursor_row;
  logic              busy;

  text_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clock100  (clock100),
    .reset_n   (reset_n),
    .char_in   (char_in),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy      (busy)
  );

  always #5 clock100 = ~clock100;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  int  errors = 0;
  int  checks = 0;
  wr_t exp_q[$];
  int  log_addr[$];
  int  log_data[$];
  int  mcol = 0;
  int  mrow = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_wr(input int addr, input int data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    exp_q.push_back(w);
  endfunction

  function automatic void push_line(input int row);
    for (int i = 0; i < COLS; i++) push_wr(row * COLS + i, 32'h20);
  endfunction

  function automatic void push_screen();
    for (int i = 0; i < COLS * ROWS; i++) push_wr(i, 32'h20);
  endfunction

  // Screen-level effect of one accepted byte; lat is the number of clock
  // edges after the accept edge during which char_ready stays low.
  function automatic void model_accept(input logic [7:0] b, output int lat);
    lat = 0;
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(mrow * COLS + mcol, int'(b));
      if (mcol == COLS - 1) begin
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
        push_line(mrow);
        lat = COLS + 1;
      end else begin
        mcol = mcol + 1;
        lat = 1;
      end
    end else if (b == 8'h0D) begin
      mcol = 0;
    end else if (b == 8'h0A) begin
      mcol = 0;
      mrow = (mrow + 1) % ROWS;
      push_line(mrow);
      lat = COLS + 1;
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol = mcol - 1;
        push_wr(mrow * COLS + mcol, 32'h20);
        lat = 1;
      end
    end else if (b == 8'h0C) begin
      mcol = 0;
      mrow = 0;
      push_screen();
      lat = COLS * ROWS + 1;
    end
  endfunction

  // Single compare process: every falling edge outside reset.
  initial begin
    forever begin
      @(negedge clock100);
      if (reset_n) begin
        check("busy_vs_ready", int'(busy), int'(!char_ready));
        check("cursor_col", int'(cursor_col), mcol);
        check("cursor_row", int'(cursor_row), mrow);
        if (ram_we) begin
          log_addr.push_back(int'(ram_addr));
          log_data.push_back(int'(ram_data));
          check("write_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            wr_t e;
            e = exp_q.pop_front();
            check("write_addr", int'(ram_addr), e.addr);
            check("write_data", int'(ram_data), e.data);
          end
        end
      end
    end
  end

  function automatic void clear_log();
    log_addr.delete();
    log_data.delete();
  endfunction

  // Called away from a rising edge. Holds char_valid/char_in until the byte
  // is accepted and the resulting busy period is over.
  task automatic send(input logic [7:0] b);
    int lat;
    int cnt;
    char_in    = b;
    char_valid = 1'b1;
    cnt = 0;
    while (!char_ready && cnt < 5000) begin
      @(negedge clock100);
      cnt++;
    end
    if (!char_ready) begin
      check("ready_timeout", 0, 1);
      char_valid = 1'b0;
      return;
    end
    @(posedge clock100);
    model_accept(b, lat);
    cnt = 0;
    @(negedge clock100);
    while (!char_ready && cnt < 4000) begin
      cnt++;
      @(negedge clock100);
    end
    check("ready_latency", cnt, lat);
    check("pending_writes", exp_q.size(), 0);
    char_valid = 1'b0;
  endtask

  // Asserts reset asynchronously, checks the reset values, then releases it
  // and follows the full-screen clear through to char_ready.
  task automatic do_reset();
    int cnt;
    char_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_ram_we", int'(ram_we), 0);
    check("rst_ram_addr", int'(ram_addr), 0);
    check("rst_ram_data", int'(ram_data), 32'h20);
    check("rst_char_ready", int'(char_ready), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_cursor_col", int'(cursor_col), 0);
    check("rst_cursor_row", int'(cursor_row), 0);
    exp_q.delete();
    mcol = 0;
    mrow = 0;
    repeat (3) @(negedge clock100);
    #1;
    push_screen();
    clear_log();
    reset_n = 1'b1;
    cnt = 0;
    @(negedge clock100);
    while (!char_ready && cnt < 4000) begin
      cnt++;
      @(negedge clock100);
    end
    check("clear_latency", cnt, 3200);
    check("clear_pending", exp_q.size(), 0);
    check("clear_count", log_addr.size(), 3200);
    if (log_addr.size() == 3200) begin
      check("clear_first_addr", log_addr[0], 0);
      check("clear_last_addr", log_addr[3199], 3199);
    end
  endtask

  initial begin
    int lat;
    int r;
    logic [7:0] b;

    #2;
    do_reset();

    // "AB", CR, "C"
    clear_log();
    send(8'h41);
    send(8'h42);
    send(8'h0D);
    send(8'h43);
    check("abc_count", log_addr.size(), 3);
    if (log_addr.size() == 3) begin
      check("abc_a_addr", log_addr[0], 0);
      check("abc_a_data", log_data[0], 32'h41);
      check("abc_b_addr", log_addr[1], 1);
      check("abc_c_addr", log_addr[2], 0);
      check("abc_c_data", log_data[2], 32'h43);
    end
    check("abc_col", int'(cursor_col), 1);
    check("abc_row", int'(cursor_row), 0);

    // Back-to-back zero-latency consumes, then BS at col 1 and at col 0.
    send(8'h0D);
    send(8'h01);
    send(8'h43);
    clear_log();
    send(8'h08);
    send(8'h08);
    check("bs_col0_count", log_addr.size(), 1);

    // Cursor to row 2 col 5, then BS.
    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h78);
    clear_log();
    send(8'h08);
    check("bs_count", log_addr.size(), 1);
    if (log_addr.size() == 1) begin
      check("bs_addr", log_addr[0], 164);
      check("bs_data", log_data[0], 32'h20);
    end
    check("bs_col", int'(cursor_col), 4);

    // LF accepted, then 0x41 held valid for the whole line clear.
    clear_log();
    @(negedge clock100);
    char_in    = 8'h0A;
    char_valid = 1'b1;
    @(posedge clock100);
    model_accept(8'h0A, lat);
    #1;
    char_in = 8'h41;
    @(negedge clock100);
    send(8'h41);
    check("hold_count", log_addr.size(), 81);
    if (log_addr.size() == 81) begin
      check("hold_line_start", log_addr[0], 3 * 80);
      check("hold_last_data", log_data[80], 32'h41);
    end

    // Form feed, then fill to row 39 col 79 and wrap with 'Z'.
    send(8'h0C);
    check("ff_col", int'(cursor_col), 0);
    check("ff_row", int'(cursor_row), 0);
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
    for (int i = 0; i < COLS - 1; i++) send(8'h61);
    check("pre_wrap_row", int'(cursor_row), 39);
    check("pre_wrap_col", int'(cursor_col), 79);
    clear_log();
    send(8'h5A);
    check("wrap_count", log_addr.size(), 81);
    if (log_addr.size() == 81) begin
      check("wrap_first_addr", log_addr[0], 3199);
      check("wrap_first_data", log_data[0], 32'h5A);
      check("wrap_line_first", log_addr[1], 0);
      check("wrap_line_last", log_addr[80], 79);
    end
    check("wrap_col", int'(cursor_col), 0);
    check("wrap_row", int'(cursor_row), 0);

    // Reset in the middle of a line clear.
    @(negedge clock100);
    char_in    = 8'h0A;
    char_valid = 1'b1;
    @(posedge clock100);
    model_accept(8'h0A, lat);
    #1;
    char_valid = 1'b0;
    repeat (20) @(negedge clock100);
    check("midline_busy", int'(busy), 1);
    #2;
    do_reset();

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70) begin
        b = 8'($urandom_range(32'h20, 32'h7E));
      end else if (r < 80) begin
        b = 8'h08;
      end else if (r < 85) begin
        b = 8'h0D;
      end else if (r < 90) begin
        b = 8'h0A;
      end else if (r < 99) begin
        b = 8'($urandom_range(0, 255));
        while ((b >= 8'h20 && b <= 8'h7E) || b == 8'h08 || b == 8'h0A ||
               b == 8'h0C || b == 8'h0D) begin
          b = 8'($urandom_range(0, 255));
        end
      end else begin
        b = 8'h0C;
      end
      send(b);
    end

    repeat (3) @(negedge clock100);
    check("final_pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
